// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-scanline walk of the sprite attribute RAM.
// Every sprite takes two words. The scanner reads both, tests the sprite for
// vertical overlap with the current line, and sends each visible sprite to the
// renderer as a decoded record over a valid/ready stream.
//
// Word layout:
//   word0: [11:0] gfx addr, [15] colour mode, [25:16] x
//   word1: [9:0] y, [11:10] height code, [16] hflip, [17] vflip, [19:18] z,
//          [23:20] collision mask, [27:24] palette, [29:28] width code
//
// Optional feature macro: SPRITE_OVERFLOW_LIMIT_EN. When it is defined, at most
// MAX_PER_LINE records are emitted per line, and the first visible sprite past
// that limit raises ovf_o.
module sprite_line_scanner #(
    parameter int unsigned MAX_PER_LINE = 16,
    parameter int unsigned NUM_SPRITES  = 128
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_i,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [6:0]  spr_idx_o,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic [9:0]  spr_x_o,
    output logic [5:0]  spr_row_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_coll_o,
    output logic [3:0]  spr_pal_o,
    output logic [1:0]  spr_width_o,
    output logic        scan_done_o,
    output logic        ovf_o
);

    if (MAX_PER_LINE < 1 || MAX_PER_LINE > 128 || NUM_SPRITES < 1 || NUM_SPRITES > 128) begin : g_param_check
        $error("sprite_line_scanner: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, RD0, RD1, EVAL, EMIT, DONE} state_t;

    state_t      state;
    logic [6:0]  n;
    logic [9:0]  line_q;
    logic [11:0] w0_addr;
    logic        w0_mode;
    logic [9:0]  w0_x;
`ifdef SPRITE_OVERFLOW_LIMIT_EN
    logic [7:0]  emitted;
`endif

    logic [9:0]  y;
    logic [1:0]  hcode;
    logic [1:0]  z;
    logic        vflip;
    logic [9:0]  h_px;
    logic [9:0]  row;
    logic [5:0]  row_out;
    logic        visible;
    logic        last;
    logic [6:0]  n_inc;
    logic        unused;

    // Decode word1 straight off the RAM data bus while in EVAL.
    // The row subtraction wraps at 1024, so sprites that cross line 1023 -> 0 still match.
    always_comb begin
        y       = rd_data_i[9:0];
        hcode   = rd_data_i[11:10];
        vflip   = rd_data_i[17];
        z       = rd_data_i[19:18];
        h_px    = 10'd8 << hcode;
        row     = line_q - y;
        visible = (z != 2'd0) && (row < h_px);
        // Only visible rows (row < h_px <= 64) reach the output, so 6-bit arithmetic is exact.
        row_out = vflip ? (h_px[5:0] - 6'd1 - row[5:0]) : row[5:0];
        last    = (n == 7'(NUM_SPRITES - 1));
        n_inc   = n + 7'd1;
    end

    assign unused = ^{rd_data_i[31:30], rd_data_i[14:12]};

    // Scan FSM. All outputs are registered. A line_start pulse in any state restarts the scan.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            n           <= '0;
            line_q      <= '0;
            w0_addr     <= '0;
            w0_mode     <= 1'b0;
            w0_x        <= '0;
`ifdef SPRITE_OVERFLOW_LIMIT_EN
            emitted     <= '0;
`endif
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            spr_valid_o <= 1'b0;
            spr_idx_o   <= '0;
            spr_addr_o  <= '0;
            spr_mode_o  <= 1'b0;
            spr_x_o     <= '0;
            spr_row_o   <= '0;
            spr_hflip_o <= 1'b0;
            spr_z_o     <= '0;
            spr_coll_o  <= '0;
            spr_pal_o   <= '0;
            spr_width_o <= '0;
            scan_done_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            scan_done_o <= 1'b0;
            if (line_start_i) begin
                line_q      <= line_i;
                n           <= '0;
                state       <= RD0;
                rd_en_o     <= 1'b1;
                rd_addr_o   <= '0;
                spr_valid_o <= 1'b0;
                ovf_o       <= 1'b0;
`ifdef SPRITE_OVERFLOW_LIMIT_EN
                emitted     <= '0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    RD0: begin
                        state     <= RD1;
                        rd_addr_o <= {n, 1'b1};
                    end
                    RD1: begin
                        state   <= EVAL;
                        rd_en_o <= 1'b0;
                        w0_addr <= rd_data_i[11:0];
                        w0_mode <= rd_data_i[15];
                        w0_x    <= rd_data_i[25:16];
                    end
                    EVAL: begin
`ifdef SPRITE_OVERFLOW_LIMIT_EN
                        if (visible && emitted == 8'(MAX_PER_LINE)) begin
                            ovf_o       <= 1'b1;
                            state       <= DONE;
                            scan_done_o <= 1'b1;
                        end else
`endif
                        if (visible) begin
                            state       <= EMIT;
                            spr_valid_o <= 1'b1;
                            spr_idx_o   <= n;
                            spr_addr_o  <= w0_addr;
                            spr_mode_o  <= w0_mode;
                            spr_x_o     <= w0_x;
                            spr_row_o   <= row_out;
                            spr_hflip_o <= rd_data_i[16];
                            spr_z_o     <= z;
                            spr_coll_o  <= rd_data_i[23:20];
                            spr_pal_o   <= rd_data_i[27:24];
                            spr_width_o <= rd_data_i[29:28];
                        end else if (last) begin
                            state       <= DONE;
                            scan_done_o <= 1'b1;
                        end else begin
                            n         <= n_inc;
                            state     <= RD0;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= {n_inc, 1'b0};
                        end
                    end
                    EMIT: begin
                        if (spr_ready_i) begin
                            spr_valid_o <= 1'b0;
`ifdef SPRITE_OVERFLOW_LIMIT_EN
                            emitted     <= emitted + 8'd1;
`endif
                            if (last) begin
                                state       <= DONE;
                                scan_done_o <= 1'b1;
                            end else begin
                                n         <= n_inc;
                                state     <= RD0;
                                rd_en_o   <= 1'b1;
                                rd_addr_o <= {n_inc, 1'b0};
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner. It includes a behavioural model of the
// attribute RAM and a reference model of the scan.
module tb_sprite_line_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [9:0]  line_in;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        spr_valid;
    logic        spr_ready;
    logic [6:0]  spr_idx;
    logic [11:0] spr_addr;
    logic        spr_mode;
    logic [9:0]  spr_x;
    logic [5:0]  spr_row;
    logic        spr_hflip;
    logic [1:0]  spr_z;
    logic [3:0]  spr_coll;
    logic [3:0]  spr_pal;
    logic [1:0]  spr_width;
    logic        scan_done;
    logic        ovf;

    sprite_line_scanner dut (
        .clk_i(clk), .rst_n_i(rst_n), .line_start_i(line_start), .line_i(line_in),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .spr_valid_o(spr_valid), .spr_ready_i(spr_ready), .spr_idx_o(spr_idx),
        .spr_addr_o(spr_addr), .spr_mode_o(spr_mode), .spr_x_o(spr_x), .spr_row_o(spr_row),
        .spr_hflip_o(spr_hflip), .spr_z_o(spr_z), .spr_coll_o(spr_coll), .spr_pal_o(spr_pal),
        .spr_width_o(spr_width), .scan_done_o(scan_done), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always_ff @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

`ifdef SPRITE_OVERFLOW_LIMIT_EN
    localparam int LIMIT = 16;
`else
    localparam int LIMIT = 1 << 30;
`endif

    typedef struct packed {
        logic [6:0]  idx;
        logic [11:0] addr;
        logic        mode;
        logic [9:0]  x;
        logic [5:0]  row;
        logic        hflip;
        logic [1:0]  z;
        logic [3:0]  coll;
        logic [3:0]  pal;
        logic [1:0]  width;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   done_cnt;
    logic ovf_at_done;
    logic exp_ovf;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic rec_t cur_rec();
        rec_t r;
        r = '{spr_idx, spr_addr, spr_mode, spr_x, spr_row, spr_hflip, spr_z,
              spr_coll, spr_pal, spr_width};
        return r;
    endfunction

    function automatic logic [31:0] mk_w0(input logic [11:0] a, input logic m, input logic [9:0] x);
        logic [31:0] w;
        w = '0; w[11:0] = a; w[15] = m; w[25:16] = x;
        return w;
    endfunction

    function automatic logic [31:0] mk_w1(input logic [9:0] y, input logic [1:0] h, input logic vf,
                                          input logic hf, input logic [1:0] z, input logic [3:0] c,
                                          input logic [3:0] p, input logic [1:0] wd);
        logic [31:0] w;
        w = '0; w[9:0] = y; w[11:10] = h; w[16] = hf; w[17] = vf; w[19:18] = z;
        w[23:20] = c; w[27:24] = p; w[29:28] = wd;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Reference: visit sprites in index order and keep those whose
    // wrapped line distance from y is less than their pixel height.
    function automatic void build_model(input logic [9:0] line);
        logic [31:0] w0, w1;
        int y, h, row;
        rec_t r;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int n = 0; n < 128; n++) begin
            w0  = mem[2*n];
            w1  = mem[2*n+1];
            y   = int'(w1[9:0]);
            h   = 8 * (1 << int'(w1[11:10]));
            row = (int'(line) - y + 1024) % 1024;
            if (w1[19:18] != 2'd0 && row < h) begin
                if (exp_q.size() == LIMIT) begin
                    exp_ovf = 1'b1;
                    break;
                end
                r.idx   = 7'(n);
                r.addr  = w0[11:0];
                r.mode  = w0[15];
                r.x     = w0[25:16];
                r.row   = w1[17] ? 6'(h - 1 - row) : 6'(row);
                r.hflip = w1[16];
                r.z     = w1[19:18];
                r.coll  = w1[23:20];
                r.pal   = w1[27:24];
                r.width = w1[29:28];
                exp_q.push_back(r);
            end
        end
    endfunction

    task automatic start_scan(input logic [9:0] line);
        @(negedge clk);
        line_start = 1'b1;
        line_in    = line;
        spr_ready  = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Drive random ready and log transfers until scan_done (bounded).
    // Also check that a stalled record is held stable and that no RAM read starts during a stall.
    task automatic collect(input int unsigned pct);
        bit   fin, stall;
        rec_t held;
        int   cyc;
        got_q.delete();
        done_cnt    = 0;
        ovf_at_done = 1'b0;
        fin         = 0;
        stall       = 0;
        held        = '0;
        cyc         = 0;
        while (!fin && cyc < 6000) begin
            if (stall) begin
                check("hold_valid", 64'(spr_valid), 64'd1);
                check("hold_rec", 64'(cur_rec()), 64'(held));
                check("hold_no_read", 64'(rd_en), 64'd0);
            end
            if (scan_done) begin
                done_cnt++;
                ovf_at_done = ovf;
                fin = 1;
            end
            spr_ready = ($urandom_range(0, 99) < pct);
            stall = spr_valid && !spr_ready;
            held  = cur_rec();
            if (spr_valid && spr_ready) got_q.push_back(cur_rec());
            @(negedge clk);
            cyc++;
        end
        if (!fin) check("scan_timeout", 64'd1, 64'd0);
        spr_ready = 1'b0;
        repeat (4) begin
            if (scan_done) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic compare_scan(input string nm);
        check({nm, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({nm, ".rec"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({nm, ".done"}, 64'(done_cnt), 64'd1);
        check({nm, ".ovf"}, 64'(ovf_at_done), 64'(exp_ovf));
    endtask

    typedef struct {
        int          idx;
        logic [9:0]  y;
        logic [1:0]  h;
        logic        vf;
        logic [1:0]  z;
        logic [9:0]  x;
        logic [11:0] addr;
        logic [9:0]  line;
        logic        vis;
        logic [5:0]  row;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst_n = 1'b0; line_start = 1'b0; line_in = '0; spr_ready = 1'b0;
        clear_mem();

        vecs[0] = '{0,   10'd3,    2'd1, 1'b0, 2'd1, 10'd60,  12'h100, 10'd5,   1'b1, 6'd2};
        vecs[1] = '{0,   10'd3,    2'd1, 1'b1, 2'd1, 10'd60,  12'h100, 10'd5,   1'b1, 6'd13};
        vecs[2] = '{0,   10'd3,    2'd1, 1'b1, 2'd1, 10'd60,  12'h100, 10'd19,  1'b0, 6'd0};
        vecs[3] = '{0,   10'd1020, 2'd0, 1'b0, 2'd1, 10'd7,   12'h0aa, 10'd2,   1'b1, 6'd6};
        vecs[4] = '{0,   10'd1020, 2'd0, 1'b0, 2'd0, 10'd7,   12'h0aa, 10'd2,   1'b0, 6'd0};
        vecs[5] = '{3,   10'd100,  2'd3, 1'b0, 2'd2, 10'd900, 12'hfff, 10'd163, 1'b1, 6'd63};
        vecs[6] = '{3,   10'd100,  2'd3, 1'b0, 2'd3, 10'd900, 12'hfff, 10'd164, 1'b0, 6'd0};
        vecs[7] = '{9,   10'd100,  2'd3, 1'b1, 2'd1, 10'd1,   12'h321, 10'd100, 1'b1, 6'd63};
        vecs[8] = '{127, 10'd0,    2'd2, 1'b0, 2'd1, 10'd512, 12'h050, 10'd31,  1'b1, 6'd31};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {cur_rec(), spr_valid, rd_en, rd_addr, scan_done, ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-sprite vectors
        for (int v = 0; v < 9; v++) begin
            logic [3:0] c, p;
            logic       hf, md;
            logic [1:0] wd;
            rec_t       e;
            c = 4'($urandom); p = 4'($urandom); hf = 1'($urandom);
            md = 1'($urandom); wd = 2'($urandom);
            clear_mem();
            mem[2*vecs[v].idx]   = mk_w0(vecs[v].addr, md, vecs[v].x);
            mem[2*vecs[v].idx+1] = mk_w1(vecs[v].y, vecs[v].h, vecs[v].vf, hf, vecs[v].z, c, p, wd);
            start_scan(vecs[v].line);
            collect(100);
            check($sformatf("vec%0d.count", v), 64'(got_q.size()), vecs[v].vis ? 64'd1 : 64'd0);
            check($sformatf("vec%0d.done", v), 64'(done_cnt), 64'd1);
            if (vecs[v].vis && got_q.size() == 1) begin
                e = '{7'(vecs[v].idx), vecs[v].addr, md, vecs[v].x, vecs[v].row, hf,
                      vecs[v].z, c, p, wd};
                check($sformatf("vec%0d.rec", v), 64'(got_q[0]), 64'(e));
            end
        end

        // Stall for 10 cycles on sprite 0; sprite 1 is also visible
        clear_mem();
        mem[0] = mk_w0(12'h111, 1'b1, 10'd20);  mem[1] = mk_w1(10'd50, 2'd0, 1'b0, 1'b1, 2'd2, 4'h5, 4'h6, 2'd1);
        mem[2] = mk_w0(12'h222, 1'b0, 10'd30);  mem[3] = mk_w1(10'd48, 2'd1, 1'b0, 1'b0, 2'd1, 4'h1, 4'h2, 2'd3);
        begin
            rec_t held;
            int   k;
            start_scan(10'd52);
            k = 0;
            while (!spr_valid && k < 20) begin @(negedge clk); k++; end
            check("stall.valid_seen", 64'(spr_valid), 64'd1);
            held = cur_rec();
            check("stall.idx", 64'(spr_idx), 64'd0);
            check("stall.row", 64'(spr_row), 64'd2);
            repeat (10) begin
                @(negedge clk);
                check("stall.valid", 64'(spr_valid), 64'd1);
                check("stall.rec", 64'(cur_rec()), 64'(held));
                check("stall.no_read", 64'(rd_en), 64'd0);
            end
            spr_ready = 1'b1;
            @(negedge clk);
            spr_ready = 1'b0;
            check("stall.valid_drop", 64'(spr_valid), 64'd0);
            check("stall.next_read", {rd_en, rd_addr}, {1'b1, 8'd2});
            collect(100);
            build_model(10'd52);
            void'(exp_q.pop_front());
            compare_scan("stall_rest");
        end

        // 17 visible sprites: overflow limit (when compiled in)
        clear_mem();
        for (int i = 0; i < 17; i++) begin
            mem[2*i]   = mk_w0(12'(i * 16), 1'b0, 10'(i * 8));
            mem[2*i+1] = mk_w1(10'd300, 2'd2, 1'b0, 1'b0, 2'd1, 4'h0, 4'(i), 2'd0);
        end
        start_scan(10'd310);
        collect(70);
        build_model(10'd310);
        compare_scan("ovf17");
`ifdef SPRITE_OVERFLOW_LIMIT_EN
        check("ovf17.hand_count", 64'(got_q.size()), 64'd16);
        check("ovf17.hand_ovf", 64'(ovf_at_done), 64'd1);
`else
        check("ovf17.hand_count", 64'(got_q.size()), 64'd17);
        check("ovf17.hand_ovf", 64'(ovf_at_done), 64'd0);
`endif

        // Restart while stalled in EMIT on sprite 5
        clear_mem();
        mem[10] = mk_w0(12'h055, 1'b0, 10'd55); mem[11] = mk_w1(10'd200, 2'd0, 1'b0, 1'b0, 2'd1, 4'h3, 4'h4, 2'd2);
        mem[4]  = mk_w0(12'h022, 1'b1, 10'd22); mem[5]  = mk_w1(10'd204, 2'd0, 1'b1, 1'b1, 2'd3, 4'h7, 4'h8, 2'd0);
        begin
            int k;
            int early_done;
            start_scan(10'd200);
            k = 0; early_done = 0;
            while (!spr_valid && k < 40) begin
                if (scan_done) early_done++;
                @(negedge clk); k++;
            end
            check("abort.valid_seen", 64'(spr_valid), 64'd1);
            check("abort.idx", 64'(spr_idx), 64'd5);
            line_start = 1'b1; line_in = 10'd204;
            @(negedge clk);
            line_start = 1'b0;
            check("abort.valid_drop", 64'(spr_valid), 64'd0);
            check("abort.restart_read", {rd_en, rd_addr}, {1'b1, 8'd0});
            check("abort.no_early_done", 64'(early_done + int'(scan_done)), 64'd0);
            collect(100);
            build_model(10'd204);
            compare_scan("abort_rescan");
        end

        // Randomised scans against the reference model
        for (int it = 0; it < 12; it++) begin
            logic [9:0] line;
            logic [31:0] w1;
            line = 10'($urandom);
            for (int s = 0; s < 128; s++) begin
                mem[2*s] = $urandom;
                w1 = $urandom;
                w1[9:0] = line - 10'($urandom_range(0, 90));
                mem[2*s+1] = w1;
            end
            start_scan(line);
            collect($urandom_range(25, 100));
            build_model(line);
            compare_scan($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
